// File: rtl/imm_encoder.sv
// ============================================================================
// imm_encoder : 32-bit immediate -> Instr[23:0] field (inverse of the extender)
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_encoder #(
  parameter int NUM_ROT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [1:0]  in_immsrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_instr,
  output logic        out_ok
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] c_last_rot = 4'(NUM_ROT - 1);

  logic [1:0]  r_state;
  logic [31:0] r_value;
  logic [3:0]  r_rot;

  logic        w_accept;
  logic [4:0]  w_shamt;
  logic [31:0] w_rotated;
  logic [23:0] w_direct_instr;
  logic        w_direct_ok;

  assign in_ready  = rst_n & (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid & in_ready;

  // Rotate left by 2*rot; a shift of 32 yields zero, so rot = 0 is a pass-through.
  assign w_shamt   = {r_rot, 1'b0};
  assign w_rotated = (r_value << w_shamt) | (r_value >> (6'd32 - {1'b0, w_shamt}));

  always_comb begin
    w_direct_instr = 24'd0;
    w_direct_ok    = 1'b0;
    case (in_immsrc)
      2'b01: begin
        w_direct_ok = ~(|in_value[31:12]);
        if (w_direct_ok) w_direct_instr = {12'd0, in_value[11:0]};
      end
      2'b10: begin
        w_direct_ok = ~(|in_value[1:0]) &
                      ((&in_value[31:25]) | ~(|in_value[31:25]));
        if (w_direct_ok) w_direct_instr = in_value[25:2];
      end
      default: begin
        w_direct_instr = 24'd0;
        w_direct_ok    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_value   <= 32'd0;
      r_rot     <= 4'd0;
      out_instr <= 24'd0;
      out_ok    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_value <= in_value;
            r_rot   <= 4'd0;
            if (in_immsrc == 2'b00) begin
              r_state <= S_SEARCH;
            end else begin
              out_instr <= w_direct_instr;
              out_ok    <= w_direct_ok;
              r_state   <= S_DONE;
            end
          end
        end
        S_SEARCH: begin
          if (~(|w_rotated[31:8])) begin
            out_instr <= {12'd0, r_rot, w_rotated[7:0]};
            out_ok    <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_rot == c_last_rot) begin
            out_instr <= 24'd0;
            out_ok    <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_rot <= r_rot + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// tb_imm_encoder : directed and random checks of imm_encoder against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = 32'd0;
  logic [1:0]  in_immsrc = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_instr;
  logic        out_ok;

  int n_checks = 0;
  int n_errors = 0;

  imm_encoder #(.NUM_ROT(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_immsrc (in_immsrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_ok    (out_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [31:0] extend(input logic [23:0] ins, input logic [1:0] src);
    case (src)
      2'b00:   return ror32({24'd0, ins[7:0]}, 2 * int'(ins[11:8]));
      2'b01:   return {20'd0, ins[11:0]};
      2'b10:   return {{6{ins[23]}}, ins, 2'b00};
      default: return 32'd0;
    endcase
  endfunction

  // Reference: search the extender's image for the first rotation that reproduces v.
  task automatic model(input logic [31:0] v, input logic [1:0] src,
                       output logic [23:0] ins, output logic ok, output int lat);
    logic [31:0] imm;
    ins = 24'd0;
    ok  = 1'b0;
    lat = 0;
    case (src)
      2'b00: begin
        lat = NR;
        for (int r = 0; r < NR; r++) begin
          imm = ror32(v, 32 - 2 * r) & 32'hFF;
          if (!ok && ror32(imm, 2 * r) == v) begin
            ok  = 1'b1;
            ins = {12'd0, 4'(r), imm[7:0]};
            lat = r + 1;
          end
        end
      end
      2'b01: begin
        ok = (v < 32'h1000);
        if (ok) ins = v[23:0];
      end
      2'b10: begin
        ok = (v % 4 == 0) && ($signed(v) >= -(2 ** 25)) && ($signed(v) < (2 ** 25));
        if (ok) ins = v[25:2];
      end
      default: ;
    endcase
  endtask

  task automatic do_req(input logic [31:0] v, input logic [1:0] src, input int hold,
                        output logic [23:0] g_instr, output logic g_ok, output int g_lat);
    logic [23:0] e_instr;
    logic        e_ok;
    int          e_lat;
    int          wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("in_ready_idle", in_ready, 1);
    in_value  = v;
    in_immsrc = src;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_value  = $urandom;
    in_immsrc = 2'($urandom_range(0, 3));
    g_lat = 0;
    while (!out_valid && g_lat < 40) begin
      @(posedge clk); #1;
      g_lat++;
    end
    g_instr = out_instr;
    g_ok    = out_ok;
    model(v, src, e_instr, e_ok, e_lat);
    check("latency", g_lat, e_lat);
    check("instr", g_instr, e_instr);
    check("ok", g_ok, e_ok);
    if (g_ok) check("roundtrip", extend(g_instr, src), v);
    repeat (hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_instr", out_instr, g_instr);
      check("hold_ok", out_ok, g_ok);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
  endtask

  function automatic logic [31:0] gen_value(input logic [1:0] src);
    logic [31:0] r;
    int          kind;
    r    = $urandom;
    kind = $urandom_range(0, 2);
    case (src)
      2'b00:
        if (kind == 0)      return ror32({24'd0, r[7:0]}, 2 * $urandom_range(0, 15));
        else if (kind == 1) return r;
        else                return ror32({23'd0, r[8:0]}, $urandom_range(0, 31));
      2'b01:
        if (kind == 2) return r;
        else           return {19'd0, r[12:0]};
      2'b10:
        if (kind == 0)      return {{7{r[31]}}, r[24:2], 2'b00};
        else if (kind == 1) return {{7{r[31]}}, r[24:0]};
        else                return r;
      default: return r;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [23:0] gi;
    logic        go;
    int          gl;
    logic [1:0]  src;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_ok", out_ok, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(32'h0000_00FF, 2'b00, 0, gi, go, gl);
    check("dp_ff_instr", gi, 24'h0000FF); check("dp_ff_ok", go, 1); check("dp_ff_lat", gl, 1);
    do_req(32'hFF00_0000, 2'b00, 0, gi, go, gl);
    check("dp_rot4_instr", gi, 24'h0004FF); check("dp_rot4_lat", gl, 5);
    do_req(32'h0000_0102, 2'b00, 0, gi, go, gl);
    check("dp_miss_ok", go, 0); check("dp_miss_instr", gi, 0); check("dp_miss_lat", gl, NR);
    do_req(32'hFFFF_FFFC, 2'b10, 0, gi, go, gl);
    check("br_neg_instr", gi, 24'hFFFFFF); check("br_neg_ok", go, 1);
    do_req(32'h0000_0006, 2'b10, 0, gi, go, gl);
    check("br_align_ok", go, 0);
    do_req(32'h0200_0000, 2'b10, 0, gi, go, gl);
    check("br_range_ok", go, 0);
    do_req(32'h0000_0ABC, 2'b01, 5, gi, go, gl);
    check("z12_instr", gi, 24'h000ABC); check("z12_ok", go, 1);
    do_req(32'h0000_1000, 2'b01, 0, gi, go, gl);
    check("z12_ovf_ok", go, 0);
    do_req(32'h0000_0001, 2'b11, 0, gi, go, gl);
    check("rsv_ok", go, 0); check("rsv_instr", gi, 0);

    // Reset while the search is at rotation 2 must drop the request.
    in_value  = 32'hFF00_0000;
    in_immsrc = 2'b00;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ok", out_ok, 0);
    check("midrst_instr", out_instr, 0);
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_result", out_valid, 0);
    end
    check("midrst_idle", in_ready, 1);

    for (int i = 0; i < 200; i++) begin
      src = 2'($urandom_range(0, 3));
      do_req(gen_value(src), src, $urandom_range(0, 3), gi, go, gl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate extender. Takes a 32-bit target immediate plus an ImmSrc code and produces the 24-bit instruction immediate field (Instr[23:0]). Feeding that field and the same ImmSrc back into the extender yields the original value.
- Data-processing immediates use an iterative rotate search, ARM style: imm8 rotated right by 2*rot.
- Sits in the assembler/loader path beside the datapath, with a valid/ready handshake on both input and output.

Parameters:
- NUM_ROT, 16, number of rotation steps searched in ImmSrc=00 mode. Legal range 1..16; 16 gives ARM compliance.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_value  input  32  immediate to encode.
- in_immsrc  input  2  immediate format: 00 = DP rotated imm8, 01 = 12-bit zero-extended, 10 = branch offset, 11 = reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_instr  output  24  encoded Instr[23:0] field.
- out_ok  output  1  1 = value is representable; 0 = not encodable (out_instr = 0).

Behaviour:
- Reset and state:
  - Sampled on clk rising edge while rst_n = 0.
  - State goes to IDLE. out_valid = 0, out_instr = 0, out_ok = 0, rotation counter = 0.
  - in_ready is 0 while rst_n = 0.
  - Reset mid-SEARCH or mid-DONE aborts the operation; no result is produced.
- States are IDLE, SEARCH and DONE. in_ready = 1 only in IDLE (and rst_n = 1).
- Accept: in_valid & in_ready at a rising edge latches in_value and in_immsrc.
- Accept with ImmSrc 01, 10 or 11: the result is computed from the inputs at that edge and the block moves to DONE. Latency is 1 cycle.
- Accept with ImmSrc 00: the block moves to SEARCH with rot = 0.
- SEARCH step (one per cycle): compute t = value rotated left by 2*rot.
  - If t[31:8] = 0: out_instr = {12'b0, rot[3:0], t[7:0]}, out_ok = 1, go to DONE.
  - Else if rot = NUM_ROT-1: out_instr = 0, out_ok = 0, go to DONE.
  - Else rot increments.
- Rotation priority: the lowest rot wins. Value 0 encodes as rot = 0, imm8 = 0.
- SEARCH latency: a hit at rotation r gives out_valid r+1 cycles after the accept edge. A miss gives NUM_ROT cycles.
- Mode 01: ok when in_value[31:12] = 0; out_instr = {12'b0, in_value[11:0]}.
- Mode 10: ok when in_value[1:0] = 0 and in_value[31:25] are all equal; out_instr = in_value[25:2].
- Mode 11: out_ok = 0, out_instr = 0.
- DONE:
  - out_valid = 1; out_instr and out_ok are held stable until out_valid & out_ready at a rising edge.
  - On that edge the block returns to IDLE and out_valid drops the next cycle.
  - There is no same-cycle accept of a new request in DONE (in_ready = 0).
- Output registers: out_instr and out_ok are registered. Their values outside DONE are don't-care but must not be X after reset.
- Inputs: in_value and in_immsrc changing after the accept edge have no effect.
- Throughput: a new request is accepted no earlier than the cycle after the output handshake.

Test Plan:
- Reset, then ImmSrc=00, in_value=0x000000FF -> out_valid 1 cycle after accept; out_instr=0x0000FF, out_ok=1.
- ImmSrc=00, in_value=0xFF000000 -> rot=4; out_instr=0x0004FF, out_ok=1; out_valid 5 cycles after accept.
- ImmSrc=00, in_value=0x00000102 (odd rotation only) -> out_ok=0, out_instr=0 after 16 cycles.
- ImmSrc=10:
  - in_value=0xFFFFFFFC -> out_instr=0xFFFFFF, ok=1.
  - in_value=0x00000006 -> ok=0.
  - in_value=0x02000000 -> ok=0.
- ImmSrc=01:
  - in_value=0x00000ABC -> out_instr=0x000ABC, ok=1.
  - in_value=0x00001000 -> ok=0.
  - ImmSrc=11 -> ok=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_instr and out_ok stable; in_ready=0.
  - Pulse rst_n=0 during SEARCH at rot=2 -> next cycle in IDLE with out_valid=0 and no result emitted.
  - Cross-check: random values through the extender give ExtImm == in_value whenever ok=1.
